// File: rtl/and_tree_bist_ctrl.sv
// rtl/and_tree_bist_ctrl.sv - BIST controller applying stuck-at patterns to an N-input AND tree
module and_tree_bist_ctrl #(
    parameter int N_IN   = 16,
    parameter int SETTLE = 1,
    localparam int P     = N_IN + 2,
    localparam int IW    = $clog2(P + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            stop_on_fail,
    input  logic            tree_out,
    output logic            test_mode,
    output logic [N_IN-1:0] tree_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [IW-1:0]   fail_count,
    output logic [IW-1:0]   first_fail_idx
);

    localparam int CW = $clog2(SETTLE + 2);
    localparam logic [IW-1:0] LAST_K  = IW'(P - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   k, k_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            sof, sof_n;
    logic            test_mode_n, busy_n, done_n, pass_n;
    logic [N_IN-1:0] tree_in_n;
    logic [IW-1:0]   fail_count_n, first_fail_idx_n;
    logic            mismatch;

    // Index 0 is all ones, 1..N_IN clear bit idx-1, N_IN+1 is all zeros.
    function automatic logic [N_IN-1:0] pattern(input logic [IW-1:0] idx);
        logic [N_IN-1:0] p;
        for (int i = 0; i < N_IN; i++) begin
            p[i] = (idx != IW'(i + 1)) && (idx != IW'(N_IN + 1));
        end
        return p;
    endfunction

    always_comb begin
        state_n          = state;
        k_n              = k;
        cnt_n            = cnt;
        sof_n            = sof;
        test_mode_n      = test_mode;
        tree_in_n        = tree_in;
        busy_n           = busy;
        done_n           = done;
        pass_n           = pass;
        fail_count_n     = fail_count;
        first_fail_idx_n = first_fail_idx;
        mismatch         = (tree_out != (k == '0));

        if (state != IDLE && abort) begin
            state_n          = IDLE;
            k_n              = '0;
            cnt_n            = '0;
            sof_n            = 1'b0;
            test_mode_n      = 1'b0;
            tree_in_n        = '0;
            busy_n           = 1'b0;
            done_n           = 1'b0;
            pass_n           = 1'b0;
            fail_count_n     = '0;
            first_fail_idx_n = '0;
        end else if (state != RUN && start && !abort) begin
            state_n          = RUN;
            k_n              = '0;
            cnt_n            = '0;
            sof_n            = stop_on_fail;
            test_mode_n      = 1'b1;
            tree_in_n        = pattern('0);
            busy_n           = 1'b1;
            done_n           = 1'b0;
            pass_n           = 1'b0;
            fail_count_n     = '0;
            first_fail_idx_n = '0;
        end else if (state == RUN) begin
            if (cnt == CNT_MAX) begin
                if (mismatch) begin
                    fail_count_n = fail_count + 1'b1;
                    if (fail_count == '0) begin
                        first_fail_idx_n = k;
                    end
                end
                if (k == LAST_K || (mismatch && sof)) begin
                    state_n     = DONE;
                    test_mode_n = 1'b0;
                    tree_in_n   = '0;
                    busy_n      = 1'b0;
                    done_n      = 1'b1;
                    pass_n      = (fail_count_n == '0);
                end else begin
                    k_n       = k + 1'b1;
                    cnt_n     = '0;
                    tree_in_n = pattern(k + 1'b1);
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            k              <= '0;
            cnt            <= '0;
            sof            <= 1'b0;
            test_mode      <= 1'b0;
            tree_in        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
        end else begin
            state          <= state_n;
            k              <= k_n;
            cnt            <= cnt_n;
            sof            <= sof_n;
            test_mode      <= test_mode_n;
            tree_in        <= tree_in_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            fail_count     <= fail_count_n;
            first_fail_idx <= first_fail_idx_n;
        end
    end

endmodule

// File: tb/tb_and_tree_bist_ctrl.sv
// tb/tb_and_tree_bist_ctrl.sv - directed vector bench for and_tree_bist_ctrl
module tb_and_tree_bist_ctrl;

    localparam int N_IN = 16;
    localparam int IW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            stop_on_fail = 1'b0;
    logic            tree_out;
    logic            test_mode;
    logic [N_IN-1:0] tree_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [IW-1:0]   fail_count;
    logic [IW-1:0]   first_fail_idx;

    // 0 = fault-free, 1 = in[5] stuck-at-1, 2 = out stuck-at-0, 3 = out stuck-at-1
    int fault = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (fault)
            1:       tree_out = &(tree_in | 16'h0020);
            2:       tree_out = 1'b0;
            3:       tree_out = 1'b1;
            default: tree_out = &tree_in;
        endcase
    end

    and_tree_bist_ctrl #(.N_IN(N_IN), .SETTLE(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .stop_on_fail   (stop_on_fail),
        .tree_out       (tree_out),
        .test_mode      (test_mode),
        .tree_in        (tree_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx)
    );

    typedef struct {
        int          fault;
        logic        sof;
        int          done_edge;
        logic        pass;
        int          fc;
        int          ffi;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [15:0] exp_pat(input int k);
        if (k == 0) return 16'hFFFF;
        if (k <= 16) return 16'hFFFF ^ (16'h0001 << (k - 1));
        return 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_tm"}, 32'(test_mode), 0);
        chk({tag, "_tin"}, 32'(tree_in), 0);
        chk({tag, "_fc"}, 32'(fail_count), 0);
        chk({tag, "_ffi"}, 32'(first_fail_idx), 0);
    endtask

    // Called #1 after a rising edge; start is taken at the next edge (E0).
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        fault = v.fault;
        stop_on_fail = v.sof;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop_on_fail = 1'b0;
        chk({tag, "_e0_busy"}, 32'(busy), 1);
        chk({tag, "_e0_done"}, 32'(done), 0);
        chk({tag, "_e0_tm"}, 32'(test_mode), 1);
        chk({tag, "_e0_tin"}, 32'(tree_in), 32'(exp_pat(0)));
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (!done && tree_in !== exp_pat(n / 2)) begin
                chk({tag, "_seq_tin"}, 32'(tree_in), 32'(exp_pat(n / 2)));
            end
            if (!done && busy !== 1'b1) chk({tag, "_seq_busy"}, 32'(busy), 1);
        end
        chk({tag, "_done_edge"}, n, v.done_edge);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_tm"}, 32'(test_mode), 0);
        chk({tag, "_tin"}, 32'(tree_in), 0);
        chk({tag, "_pass"}, 32'(pass), 32'(v.pass));
        chk({tag, "_fc"}, 32'(fail_count), v.fc);
        if (v.fc != 0) chk({tag, "_ffi"}, 32'(first_fail_idx), v.ffi);
    endtask

    initial begin
        vecs[0] = '{fault: 0, sof: 1'b0, done_edge: 36, pass: 1'b1, fc: 0,  ffi: 0};
        vecs[1] = '{fault: 1, sof: 1'b0, done_edge: 36, pass: 1'b0, fc: 1,  ffi: 6};
        vecs[2] = '{fault: 2, sof: 1'b0, done_edge: 36, pass: 1'b0, fc: 1,  ffi: 0};
        vecs[3] = '{fault: 3, sof: 1'b0, done_edge: 36, pass: 1'b0, fc: 17, ffi: 1};
        vecs[4] = '{fault: 1, sof: 1'b1, done_edge: 14, pass: 1'b0, fc: 1,  ffi: 6};
        vecs[5] = '{fault: 2, sof: 1'b1, done_edge: 2,  pass: 1'b0, fc: 1,  ffi: 0};

        #1;
        chk_idle("rst");
        #22;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("post_rst");

        // Back-to-back: each run after the first starts from DONE.
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Abort in DONE returns to IDLE with cleared results.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_idle("abort_done");

        // Abort mid-run: asserted after E10, IDLE after E11.
        fault = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pre_busy", 32'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_idle("abort_run");
        run_vec(vecs[0], "after_abort");

        // Start and abort together from IDLE.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk_idle("start_abort");
        @(posedge clk); #1;
        chk_idle("start_abort2");

        // Asynchronous reset mid-run.
        fault = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("rst_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
